// File: rtl/alu_operand_pkg.sv
// Shared types and sizing for the ALU operand stage: operand-select encodings and skid FIFO geometry.
package alu_operand_pkg;

    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned FIFO_PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        A_UP  = 2'd0,
        A_JT  = 2'd1,
        A_BT  = 2'd2,
        A_RS1 = 2'd3
    } a_sel_e;

    // Encodings 6 and 7 are illegal and select a zero operand.
    typedef enum logic [2:0] {
        B_LI     = 3'd0,
        B_ST     = 3'd1,
        B_PC     = 3'd2,
        B_RS2IDX = 3'd3,
        B_RS2    = 3'd4,
        B_PC4    = 3'd5
    } b_sel_e;

    function automatic logic [FIFO_PTR_W-1:0] ptr_inc(input logic [FIFO_PTR_W-1:0] p);
        return (p == FIFO_PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + FIFO_PTR_W'(1);
    endfunction

endpackage

// File: rtl/alu_operand_stage_if.sv
// Decode-to-ALU operand bus: request side (selects, immediates, register data) and operand-pair output.
interface alu_operand_stage_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned PC_W = 30
);
    import alu_operand_pkg::*;

    logic            in_valid;
    logic            in_ready;
    a_sel_e          a_sel;
    logic [2:0]      b_sel;
    logic [XLEN-1:0] imm_up;
    logic [XLEN-1:0] imm_j;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [4:0]      rs2_idx;
    logic [PC_W-1:0] pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic            sel_err;

    modport master (
        output in_valid, a_sel, b_sel, imm_up, imm_j, imm_b, imm_i, imm_s,
               rs1_data, rs2_data, rs2_idx, pc, out_ready,
        input  in_ready, out_valid, alu_a, alu_b, sel_err
    );

    modport slave (
        input  in_valid, a_sel, b_sel, imm_up, imm_j, imm_b, imm_i, imm_s,
               rs1_data, rs2_data, rs2_idx, pc, out_ready,
        output in_ready, out_valid, alu_a, alu_b, sel_err
    );

endinterface

// File: rtl/operand_skid_fifo.sv
// Two-entry skid FIFO holding ALU operand pairs; count and pointers reset synchronously to zero.
module operand_skid_fifo
    import alu_operand_pkg::*;
#(
    parameter int unsigned W = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic [W-1:0]          wr_data,
    output logic [W-1:0]          rd_data,
    output logic [FIFO_CNT_W-1:0] count
);

    logic [W-1:0]          mem [FIFO_DEPTH];
    logic [FIFO_PTR_W-1:0] wr_ptr;
    logic [FIFO_PTR_W-1:0] rd_ptr;
    logic [FIFO_CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            if (push && !pop) begin
                count_q <= count_q + FIFO_CNT_W'(1);
            end else if (pop && !push) begin
                count_q <= count_q - FIFO_CNT_W'(1);
            end
        end
    end

    assign rd_data = mem[rd_ptr];
    assign count   = count_q;

endmodule

// File: rtl/alu_operand_stage.sv
// ALU operand select plus skid buffer between decode and the ALU.
// Optional operand forwarding is compiled in with OPERAND_FWD_EN.
module alu_operand_stage
    import alu_operand_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned PC_W = 30
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clk_enable,
`ifdef OPERAND_FWD_EN
    input  logic            fwd_valid,
    input  logic [4:0]      fwd_idx,
    input  logic [XLEN-1:0] fwd_data,
    input  logic [4:0]      rs1_idx,
    input  logic [4:0]      rs2_idx_fwd,
`endif
    alu_operand_stage_if.slave bus
);

    logic [XLEN-1:0]       rs1_sel;
    logic [XLEN-1:0]       rs2_sel;
    logic [XLEN-1:0]       op_a;
    logic [XLEN-1:0]       op_b;
    logic [XLEN-1:0]       pc_byte;
    logic                  b_illegal;
    logic                  push;
    logic                  pop;
    logic [FIFO_CNT_W-1:0] count;
    logic [2*XLEN-1:0]     rd_data;
    logic                  sel_err_q;

    assign bus.in_ready  = rst_n && clk_enable && (count < FIFO_CNT_W'(FIFO_DEPTH));
    assign bus.out_valid = (count != '0);
    assign push          = clk_enable && bus.in_valid && bus.in_ready;
    assign pop           = clk_enable && bus.out_valid && bus.out_ready;

`ifdef OPERAND_FWD_EN
    // Index 0 is the hard-wired zero register and never forwards.
    always_comb begin
        rs1_sel = bus.rs1_data;
        rs2_sel = bus.rs2_data;
        if (fwd_valid && (fwd_idx != 5'd0) && (fwd_idx == rs1_idx)) begin
            rs1_sel = fwd_data;
        end
        if (fwd_valid && (fwd_idx != 5'd0) && (fwd_idx == rs2_idx_fwd)) begin
            rs2_sel = fwd_data;
        end
    end
`else
    assign rs1_sel = bus.rs1_data;
    assign rs2_sel = bus.rs2_data;
`endif

    assign pc_byte = XLEN'({bus.pc, 2'b00});

    always_comb begin
        op_a = rs1_sel;
        case (bus.a_sel)
            A_UP:    op_a = bus.imm_up;
            A_JT:    op_a = bus.imm_j;
            A_BT:    op_a = bus.imm_b;
            default: op_a = rs1_sel;
        endcase
    end

    always_comb begin
        op_b      = '0;
        b_illegal = 1'b0;
        case (bus.b_sel)
            B_LI:     op_b = bus.imm_i;
            B_ST:     op_b = bus.imm_s;
            B_PC:     op_b = pc_byte;
            B_RS2IDX: op_b = XLEN'(bus.rs2_idx);
            B_RS2:    op_b = rs2_sel;
            B_PC4:    op_b = pc_byte + XLEN'(4);
            default:  b_illegal = 1'b1;
        endcase
    end

    operand_skid_fifo #(
        .W (2 * XLEN)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .pop     (pop),
        .wr_data ({op_a, op_b}),
        .rd_data (rd_data),
        .count   (count)
    );

    assign bus.alu_a = rd_data[2*XLEN-1:XLEN];
    assign bus.alu_b = rd_data[XLEN-1:0];

    // Sticky until reset once an illegal B select has been accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_err_q <= 1'b0;
        end else if (push && b_illegal) begin
            sel_err_q <= 1'b1;
        end
    end

    assign bus.sel_err = sel_err_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed scoreboard bench for alu_operand_stage; forwarding steps run when OPERAND_FWD_EN is defined.
module tb_alu_operand_stage;
    import alu_operand_pkg::*;

    localparam int unsigned XLEN = 32;
    localparam int unsigned PC_W = 30;

    typedef logic [2*XLEN-1:0] pair_t;

    logic clk        = 1'b0;
    logic rst_n      = 1'b0;
    logic clk_enable = 1'b1;

    always #5 clk = ~clk;

    alu_operand_stage_if #(.XLEN(XLEN), .PC_W(PC_W)) bus ();

`ifdef OPERAND_FWD_EN
    logic            fwd_valid   = 1'b0;
    logic [4:0]      fwd_idx     = 5'd0;
    logic [XLEN-1:0] fwd_data    = '0;
    logic [4:0]      rs1_idx     = 5'd0;
    logic [4:0]      rs2_idx_fwd = 5'd0;
`endif

    alu_operand_stage #(.XLEN(XLEN), .PC_W(PC_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clk_enable  (clk_enable),
`ifdef OPERAND_FWD_EN
        .fwd_valid   (fwd_valid),
        .fwd_idx     (fwd_idx),
        .fwd_data    (fwd_data),
        .rs1_idx     (rs1_idx),
        .rs2_idx_fwd (rs2_idx_fwd),
`endif
        .bus         (bus.slave)
    );

    pair_t sb[$];
    logic  err_m = 1'b0;
    int    total = 0;
    int    bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference operand pair for the inputs currently driven.
    function automatic pair_t ref_pair();
        logic [XLEN-1:0] a, b, r1, r2, pcb;
        r1 = bus.rs1_data;
        r2 = bus.rs2_data;
`ifdef OPERAND_FWD_EN
        if (fwd_valid && fwd_idx != 5'd0 && fwd_idx == rs1_idx) r1 = fwd_data;
        if (fwd_valid && fwd_idx != 5'd0 && fwd_idx == rs2_idx_fwd) r2 = fwd_data;
`endif
        pcb = XLEN'(bus.pc) << 2;
        case (bus.a_sel)
            A_UP:    a = bus.imm_up;
            A_JT:    a = bus.imm_j;
            A_BT:    a = bus.imm_b;
            default: a = r1;
        endcase
        case (bus.b_sel)
            3'd0:    b = bus.imm_i;
            3'd1:    b = bus.imm_s;
            3'd2:    b = pcb;
            3'd3:    b = {27'd0, bus.rs2_idx};
            3'd4:    b = r2;
            3'd5:    b = pcb + 32'd4;
            default: b = 32'd0;
        endcase
        return {a, b};
    endfunction

    // One clock: check outputs on the falling edge, then advance the model across the rising edge.
    task automatic cycle();
        logic  push, pop;
        pair_t p;
        @(negedge clk);
        chk("out_valid", 64'(bus.out_valid), 64'(sb.size() != 0));
        chk("in_ready", 64'(bus.in_ready), 64'(rst_n && clk_enable && sb.size() < 2));
        chk("sel_err", 64'(bus.sel_err), 64'(err_m));
        if (sb.size() != 0) chk("head_pair", {bus.alu_a, bus.alu_b}, sb[0]);
        push = clk_enable && rst_n && bus.in_valid && (sb.size() < 2);
        pop  = clk_enable && rst_n && bus.out_ready && (sb.size() != 0);
        p    = ref_pair();
        @(posedge clk);
        if (!rst_n) begin
            sb.delete();
            err_m = 1'b0;
        end else begin
            if (pop) void'(sb.pop_front());
            if (push) begin
                sb.push_back(p);
                if (bus.b_sel > 3'd5) err_m = 1'b1;
            end
        end
        #1;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a_sel     = A_UP;
        bus.b_sel     = 3'd0;
        bus.imm_up    = 32'h0;
        bus.imm_j     = 32'h1111_0000;
        bus.imm_b     = 32'h2222_0000;
        bus.imm_i     = 32'h0000_0123;
        bus.imm_s     = 32'h0000_0456;
        bus.rs1_data  = 32'hAAAA_5555;
        bus.rs2_data  = 32'h5555_AAAA;
        bus.rs2_idx   = 5'd17;
        bus.pc        = 30'h0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        cycle();
        chk("rst_alu_a", 64'(bus.alu_a), 64'h0);
        chk("rst_alu_b", 64'(bus.alu_b), 64'h0);
        rst_n = 1'b1;

        // Test 1: UP + PC, one-cycle latency
        bus.a_sel     = A_UP;
        bus.imm_up    = 32'h1234_5000;
        bus.b_sel     = 3'd2;
        bus.pc        = 30'h4;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        cycle();
        bus.in_valid = 1'b0;
        chk("t1_valid", 64'(bus.out_valid), 64'h1);
        chk("t1_alu_a", 64'(bus.alu_a), 64'h1234_5000);
        chk("t1_alu_b", 64'(bus.alu_b), 64'h10);
        cycle();

        // Test 2: PC4 wraps to zero
        bus.b_sel    = 3'd5;
        bus.pc       = 30'h3FFF_FFFF;
        bus.in_valid = 1'b1;
        cycle();
        bus.in_valid = 1'b0;
        chk("t2_alu_b", 64'(bus.alu_b), 64'h0);
        cycle();

        // Test 3: stalled ALU, three back-to-back requests
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.b_sel     = 3'd3;
        for (int i = 0; i < 3; i++) begin
            bus.imm_up = 32'hA000_0000 + 32'(i);
            cycle();
        end
        chk("t3_in_ready", 64'(bus.in_ready), 64'h0);
        chk("t3_head", 64'(bus.alu_a), 64'hA000_0000);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) cycle();
        chk("t3_drained", 64'(sb.size()), 64'h0);

        // Test 4: steady push+pop at count==1
        bus.in_valid = 1'b1;
        cycle();
        for (int i = 0; i < 5; i++) begin
            bus.a_sel    = a_sel_e'(2'($urandom_range(3)));
            bus.b_sel    = 3'($urandom_range(5));
            bus.imm_up   = $urandom;
            bus.imm_i    = $urandom;
            bus.rs1_data = $urandom;
            bus.rs2_data = $urandom;
            bus.rs2_idx  = 5'($urandom);
            bus.pc       = 30'($urandom);
            cycle();
            chk("t4_valid", 64'(bus.out_valid), 64'h1);
        end
        bus.in_valid = 1'b0;
        repeat (2) cycle();

        // Global stall freezes all state
        bus.a_sel     = A_JT;
        bus.b_sel     = 3'd1;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        cycle();
        clk_enable    = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) cycle();
        clk_enable   = 1'b1;
        bus.in_valid = 1'b0;
        repeat (2) cycle();

        // Test 5: illegal b_sel, sticky error, reset while full
        bus.b_sel    = 3'd7;
        bus.a_sel    = A_BT;
        bus.in_valid = 1'b1;
        cycle();
        bus.in_valid = 1'b0;
        chk("t5_alu_b", 64'(bus.alu_b), 64'h0);
        chk("t5_sel_err", 64'(bus.sel_err), 64'h1);
        repeat (3) cycle();
        bus.b_sel     = 3'd0;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        repeat (2) cycle();
        chk("t5_full", 64'(bus.in_ready), 64'h0);
        rst_n = 1'b0;
        cycle();
        chk("t5_rst_valid", 64'(bus.out_valid), 64'h0);
        chk("t5_rst_alu_a", 64'(bus.alu_a), 64'h0);
        chk("t5_rst_alu_b", 64'(bus.alu_b), 64'h0);
        chk("t5_rst_err", 64'(bus.sel_err), 64'h0);
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        cycle();

`ifdef OPERAND_FWD_EN
        // Test 6: forwarding onto rs1
        bus.out_ready = 1'b1;
        bus.a_sel     = A_RS1;
        bus.b_sel     = 3'd4;
        rs1_idx       = 5'd5;
        rs2_idx_fwd   = 5'd6;
        fwd_valid     = 1'b1;
        fwd_idx       = 5'd5;
        fwd_data      = 32'hDEAD;
        bus.in_valid  = 1'b1;
        cycle();
        bus.in_valid = 1'b0;
        chk("t6_fwd", 64'(bus.alu_a), 64'hDEAD);
        cycle();
        fwd_idx      = 5'd0;
        rs1_idx      = 5'd0;
        bus.in_valid = 1'b1;
        cycle();
        bus.in_valid = 1'b0;
        chk("t6_nofwd", 64'(bus.alu_a), 64'(bus.rs1_data));
        cycle();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
